// File: rtl/precompute_gadget.sv
`default_nettype none
// ============================================================================
// Module   : precompute_gadget
// Purpose  : Scans a power-of-two gadget base Bg bit-serially to find its
//            exponent b, then generates L gadget levels Q >> (b*(i+1)), with
//            optional round-half-up, one level per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module precompute_gadget #(
  parameter int DATA_WIDTH = 32,
  parameter int n_WIDTH    = 8,
  parameter int L          = 3
) (
  input  logic                         clk,
  input  logic                         rst,       // asynchronous, active-low
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] Bg,
  input  logic signed [DATA_WIDTH-1:0] Q,
  input  logic                         round_en,
  output logic [L*DATA_WIDTH-1:0]      GPow,
  output logic                         ready,
  output logic                         done,
  output logic                         err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GEN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   bg_q, bg_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    rnd_q, rnd_d;
  logic [n_WIDTH-1:0]      cnt_q, cnt_d;      // scan bit index
  logic [n_WIDTH-1:0]      pop_q, pop_d;      // set bits seen so far
  logic [n_WIDTH-1:0]      b_q, b_d;          // index of the set bit
  logic [n_WIDTH-1:0]      lvl_q, lvl_d;      // level being generated
  logic [n_WIDTH-1:0]      shift_q, shift_d;  // b*(lvl+1), kept as a running sum
  logic [L*DATA_WIDTH-1:0] gpow_q, gpow_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   bg_shr;
  logic                    scan_bit;
  logic                    inputs_valid;
  logic [DATA_WIDTH:0]     half;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH-1:0]   level_trunc;
  logic [DATA_WIDTH-1:0]   level_rnd;
  logic [DATA_WIDTH-1:0]   level_val;

  // Level datapath: truncating and round-half-up shift of Q by the current shift amount
  always_comb begin
    bg_shr      = bg_q >> cnt_q;
    scan_bit    = bg_shr[0];
    inputs_valid = (pop_q == n_WIDTH'(1)) && (b_q != '0) &&
                   (b_q != n_WIDTH'(DATA_WIDTH - 1)) && !q_q[DATA_WIDTH-1];
    // shift is always >= 1 while generating, so shift-1 never underflows there;
    // in other states the value is unused.
    half        = (DATA_WIDTH+1)'(1) << (shift_q - n_WIDTH'(1));
    sum         = {1'b0, q_q} + half;                 // one extra bit: cannot overflow
    level_trunc = q_q >> shift_q;
    level_rnd   = DATA_WIDTH'(sum >> shift_q);        // top bit is zero since shift >= 1
    if (shift_q >= n_WIDTH'(DATA_WIDTH)) begin
      level_val = '0;
    end else begin
      level_val = rnd_q ? level_rnd : level_trunc;
    end
  end

  // Next-state and datapath update for the IDLE/SCAN/GEN/DONE controller
  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    q_d     = q_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    pop_d   = pop_q;
    b_d     = b_q;
    lvl_d   = lvl_q;
    shift_d = shift_q;
    gpow_d  = gpow_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bg_d    = Bg;
          q_d     = Q;
          rnd_d   = round_en;
          err_d   = 1'b0;
          gpow_d  = '0;
          cnt_d   = '0;
          pop_d   = '0;
          b_d     = '0;
          lvl_d   = '0;
          shift_d = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // Counts 0..DATA_WIDTH-1 examine one bit each; count DATA_WIDTH is a
        // decision cycle that judges the fully registered popcount and index.
        if (cnt_q < n_WIDTH'(DATA_WIDTH)) begin
          if (scan_bit) begin
            pop_d = pop_q + n_WIDTH'(1);
            b_d   = cnt_q;
          end
          cnt_d = cnt_q + n_WIDTH'(1);
        end else if (inputs_valid) begin
          lvl_d   = '0;
          shift_d = b_q;
          state_d = ST_GEN;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_GEN: begin
        for (int i = 0; i < L; i++) begin
          if (lvl_q == n_WIDTH'(i)) begin
            gpow_d[i*DATA_WIDTH +: DATA_WIDTH] = level_val;
          end
        end
        if (lvl_q == n_WIDTH'(L - 1)) begin
          state_d = ST_DONE;
        end else begin
          lvl_d   = lvl_q + n_WIDTH'(1);
          shift_d = shift_q + b_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset takes effect without a clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bg_q    <= '0;
      q_q     <= '0;
      rnd_q   <= 1'b0;
      cnt_q   <= '0;
      pop_q   <= '0;
      b_q     <= '0;
      lvl_q   <= '0;
      shift_q <= '0;
      gpow_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      q_q     <= q_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
      pop_q   <= pop_d;
      b_q     <= b_d;
      lvl_q   <= lvl_d;
      shift_q <= shift_d;
      gpow_q  <= gpow_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode directly from registered state
  always_comb begin
    GPow  = gpow_q;
    err   = err_q;
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_precompute_gadget.sv
`default_nettype none
// ============================================================================
// Module   : tb_precompute_gadget
// Purpose  : Self-checking bench for precompute_gadget (vector table,
//            reference-model random stimulus, reset/busy corner sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_precompute_gadget;

  localparam int DW = 32;
  localparam int NL = 3;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic signed [DW-1:0]  Bg;
  logic signed [DW-1:0]  Q;
  logic                  round_en;
  logic [NL*DW-1:0]      GPow;
  logic                  ready;
  logic                  done;
  logic                  err;

  int n_tests = 0;
  int n_fail  = 0;

  precompute_gadget #(
    .DATA_WIDTH (DW),
    .n_WIDTH    (8),
    .L          (NL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Bg       (Bg),
    .Q        (Q),
    .round_en (round_en),
    .GPow     (GPow),
    .ready    (ready),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bg;
    logic [31:0] q;
    logic        rnd;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        e_err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: computed directly from the arithmetic definition of a gadget level
  task automatic model(input logic [31:0] bg, input logic [31:0] q, input logic rnd,
                       output logic [95:0] g, output logic e, output int lat);
    int b;
    int pc;
    logic [63:0] v;
    pc = $countones(bg);
    b  = -1;
    for (int i = 0; i < 32; i++) if (bg[i]) b = i;
    e  = (pc != 1) || (b == 0) || (b == 31) || q[31];
    g  = '0;
    if (!e) begin
      for (int i = 0; i < NL; i++) begin
        int s;
        s = b * (i + 1);
        if (s < 32) begin
          v = {32'b0, q};
          if (rnd) v = v + (64'd1 << (s - 1));
          v = v >> s;
          g[i*32 +: 32] = v[31:0];
        end
      end
    end
    lat = e ? 33 : 36;
  endtask

  // One request: drive start, measure latency to done, check results and hold
  task automatic run_op(input logic [31:0] bg, input logic [31:0] q, input logic rnd,
                        input logic [95:0] eg, input logic eerr, input int elat,
                        input bit poke, input string tag);
    int k;
    bit saw_ready;
    @(negedge clk);
    Bg = bg; Q = q; round_en = rnd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_clr"}, GPow, 96'd0);
    k = 0;
    saw_ready = 1'b0;
    while (!done && k < 200) begin
      if (ready) saw_ready = 1'b1;
      if (poke && k == 5) begin start = 1'b1; Bg = 32'h0000_0300; Q = 32'h8000_0000; round_en = ~rnd; end
      if (poke && k == 6) begin start = 1'b0; end
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles required done", tag, k);
    end
    chk({tag, "_lat"},   96'(k),         96'(elat));
    chk({tag, "_err"},   96'(err),       96'(eerr));
    chk({tag, "_gpow"},  GPow,           eg);
    chk({tag, "_busy"},  96'(saw_ready), 96'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {94'd0, done, ready}, 96'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_hold"},  {GPow ^ eg, 1'b0}, {96'd0, 1'b0});
  endtask

  initial begin
    logic [95:0] g;
    logic        e;
    int          lat;
    int          k;
    int          done_seen;
    logic [31:0] rbg;
    logic [31:0] rq;
    logic        rr;

    vecs[0]  = '{32'h0000_0100, 32'h7FFF_F000, 1'b0, 32'h007F_FFF0, 32'h0000_7FFF, 32'h0000_007F, 1'b0, 36};
    vecs[1]  = '{32'h0000_0100, 32'h7FFF_F000, 1'b1, 32'h007F_FFF0, 32'h0000_8000, 32'h0000_0080, 1'b0, 36};
    vecs[2]  = '{32'h0020_0000, 32'h7FFF_F000, 1'b0, 32'h0000_03FF, 32'h0,         32'h0,         1'b0, 36};
    vecs[3]  = '{32'h0020_0000, 32'h7FFF_F000, 1'b1, 32'h0000_0400, 32'h0,         32'h0,         1'b0, 36};
    vecs[4]  = '{32'h0000_0300, 32'h7FFF_F000, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 33};
    vecs[5]  = '{32'h0000_0001, 32'h7FFF_F000, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 33};
    vecs[6]  = '{32'h0000_0100, 32'h8000_0000, 1'b1, 32'h0,         32'h0,         32'h0,         1'b1, 33};
    vecs[7]  = '{32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 33};
    vecs[8]  = '{32'h8000_0000, 32'h0000_1234, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 33};
    vecs[9]  = '{32'h0000_0002, 32'h7FFF_FFFF, 1'b1, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 1'b0, 36};
    vecs[10] = '{32'h4000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0002, 32'h0,         32'h0,         1'b0, 36};
    vecs[11] = '{32'h4000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 32'h0,         32'h0,         1'b0, 36};

    rst = 1'b0; start = 1'b0; Bg = '0; Q = '0; round_en = 1'b0;
    #1;
    chk("reset_state", {GPow, done, err, ready}, {96'd0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].bg, vecs[i].q, vecs[i].rnd, {vecs[i].e2, vecs[i].e1, vecs[i].e0},
             vecs[i].e_err, vecs[i].lat, (i == 1), $sformatf("vec%0d", i));
    end

    // Reset in the middle of generation: everything clears at once, no done
    @(negedge clk);
    Bg = 32'h0000_0100; Q = 32'h7FFF_F000; round_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 34 && !done; k++) @(negedge clk);
    chk("mid_gen_busy", {94'd0, ready, done}, 96'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", {GPow, done, err, ready}, {96'd0, 1'b0, 1'b0, 1'b1});
    done_seen = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("no_done_after_abort", 96'(done_seen), 96'd0);
    rst = 1'b1;
    run_op(vecs[1].bg, vecs[1].q, vecs[1].rnd, {vecs[1].e2, vecs[1].e1, vecs[1].e0},
           1'b0, 36, 1'b1, "post_reset");

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    rbg = 32'd1 << $urandom_range(0, 31);
        2:       rbg = $urandom;
        default: rbg = (32'd1 << $urandom_range(1, 30)) | (32'd1 << $urandom_range(0, 31));
      endcase
      rq = $urandom;
      if ($urandom_range(0, 3) != 0) rq[31] = 1'b0;
      rr = 1'($urandom_range(0, 1));
      model(rbg, rq, rr, g, e, lat);
      run_op(rbg, rq, rr, g, e, lat, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
